// File: rtl/apa102_out.sv
// APA102 frame transmitter: start frame of zeros, NUM_LEDS snapshot words MSB first, end frame of ones.
// Optional APA102_OUT_GLOBAL_BRIGHTNESS_EN adds global_brightness and overrides each LED word's top byte.
`timescale 1ns/1ps

module apa102_out #(
  parameter int NUM_LEDS = 7,
  parameter int CLK_DIV  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [32*NUM_LEDS-1:0]   data_in,
  input  logic                     start,
`ifdef APA102_OUT_GLOBAL_BRIGHTNESS_EN
  input  logic [4:0]               global_brightness,
`endif
  output logic                     sck,
  output logic                     sda,
  output logic                     busy,
  output logic                     done
);

  localparam int DATA_BITS  = 32 * NUM_LEDS;
  localparam int TOTAL_BITS = 32 * (NUM_LEDS + 2);
  localparam int CNT_W      = $clog2(TOTAL_BITS) + 1;
  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CNT_W-1:0] START_END = CNT_W'(32);
  localparam logic [CNT_W-1:0] DATA_END  = CNT_W'(32 + DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(TOTAL_BITS - 1);
  localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_END,
    ST_DONE
  } state_t;

  state_t                 state;
  logic [DIV_W-1:0]       div_cnt;
  logic [CNT_W-1:0]       bit_cnt;
  logic [CNT_W-1:0]       next_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic [DATA_BITS-1:0]   load_word;

  assign next_cnt = bit_cnt + CNT_W'(1);

  // Word image captured at accept; the brightness option rewrites each LED's header byte.
  always_comb begin
    load_word = data_in;
`ifdef APA102_OUT_GLOBAL_BRIGHTNESS_EN
    for (int i = 0; i < NUM_LEDS; i++) begin
      load_word[32*i +: 32] = {3'b111, global_brightness, data_in[32*i +: 24]};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sck     <= 1'b0;
      sda     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          div_cnt <= '0;
          done    <= 1'b0;
          if (start) begin
            shreg   <= load_word;
            bit_cnt <= '0;
            sck     <= 1'b0;
            sda     <= 1'b0;
            busy    <= 1'b1;
            state   <= ST_START;
          end
        end

        ST_START, ST_DATA, ST_END: begin
          if (div_cnt != DIV_MAX) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            if (!sck) begin
              sck <= 1'b1;
            end else begin
              // Falling edge: either finish the frame or present the next bit.
              sck <= 1'b0;
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                sda     <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b1;
                state   <= ST_DONE;
              end else begin
                bit_cnt <= next_cnt;
                if (state == ST_DATA) begin
                  shreg <= shreg << 1;
                end
                if (next_cnt == START_END) begin
                  sda   <= shreg[DATA_BITS-1];
                  state <= ST_DATA;
                end else if (next_cnt == DATA_END) begin
                  sda   <= 1'b1;
                  state <= ST_END;
                end else if (state == ST_DATA) begin
                  sda <= shreg[DATA_BITS-2];
                end
              end
            end
          end
        end

        ST_DONE: begin
          div_cnt <= '0;
          done    <= 1'b0;
          state   <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
